// File: rtl/mux_arb_pkg.sv
// Shared types and default sizing for the round-robin output mux arbiter.
package mux_arb_pkg;
  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
endpackage

// File: rtl/round_robin_select.sv
// Combinational round-robin pick: first valid requester at or after ptr, modulo N_REQ.
module round_robin_select #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PW-1:0]    ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant
);
  logic [PW:0] idx;
  logic        found;

  // One extra bit on idx lets ptr+k exceed N_REQ-1 before the explicit wrap,
  // which keeps non-power-of-two N_REQ correct.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    if (en) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = {1'b0, ptr} + (PW+1)'(k);
        if (idx >= (PW+1)'(N_REQ))
          idx = idx - (PW+1)'(N_REQ);
        if (!found && valid[idx[PW-1:0]]) begin
          grant[idx[PW-1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/mux_round_robin_arbiter.sv
// N-way round-robin arbiter feeding a single output register; 1-cycle latency,
// sustains one word per cycle when the downstream drains every cycle.
module mux_round_robin_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [N_REQ-1:0]       grant
);
  localparam int PW = $clog2(N_REQ);

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, ptr_nxt, win;
  logic [WIDTH-1:0]  mux_data;
  logic              space, xfer;

  assign space = (state == ST_EMPTY) || out_ready;

  round_robin_select #(.N_REQ(N_REQ), .PW(PW)) u_sel (
    .valid (req_valid),
    .ptr   (ptr),
    .en    (space && !rst),
    .grant (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign out_valid = (state == ST_FULL);

  // Grant is one-hot, so OR-ing the gated words is the mux.
  always_comb begin
    mux_data = '0;
    win      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        mux_data = mux_data | req_data[i*WIDTH +: WIDTH];
        win      = PW'(i);
      end
    end
  end

  assign ptr_nxt = (win == PW'(N_REQ-1)) ? '0 : win + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (xfer) state_nxt = ST_FULL;
      ST_FULL:  if (!xfer && out_ready) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        out_data <= mux_data;
        ptr      <= ptr_nxt;
      end
    end
  end
endmodule

// File: tb/tb_mux_round_robin_arbiter.sv
// Directed bench for mux_round_robin_arbiter: inputs driven and outputs sampled 1ns after negedge.
module tb_mux_round_robin_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [3:0]  grant;

  int n_chk  = 0;
  int n_pass = 0;
  logic saw77 = 1'b0;

  mux_round_robin_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && out_valid && out_ready && out_data == 8'h77) saw77 <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_data(input logic [7:0] d0, d1, d2, d3);
    req_data = {d3, d2, d1, d0};
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; req_valid = 4'hF;
    set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);

    // reset with all requesters valid
    for (int c = 0; c < 2; c++) begin
      nxt();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data",  32'(out_data),  0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_grant",     32'(grant),     0);
    end

    // saturation: A0,A1,A2,A3,A0 with rotating grant
    rst = 1'b0; out_ready = 1'b1; #1;
    chk("first_grant", 32'(grant), 32'b0001);
    chk("first_ready", 32'(req_ready), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      nxt();
      chk("sat_valid", 32'(out_valid), 1);
      chk("sat_data",  32'(out_data),  32'(8'hA0 + (k % 4)));
      chk("sat_grant", 32'(grant),     32'(1 << ((k + 1) % 4)));
    end

    // load 55 from requester 1, then backpressure for 5 cycles
    req_valid = 4'b0010; set_data(8'hA0, 8'h55, 8'hA2, 8'hA3); #1;
    chk("bp_load_grant", 32'(grant), 32'b0010);
    nxt();
    out_ready = 1'b0; req_valid = 4'hF; set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3); #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_data",  32'(out_data),  32'h55);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_ready", 32'(req_ready), 0);
      nxt();
    end
    out_ready = 1'b1; #1;
    chk("bp_resume_grant", 32'(grant), 32'b0100);
    nxt();
    chk("bp_resume_data", 32'(out_data), 32'hA2);
    chk("bp_next_grant",  32'(grant),    32'b1000);

    // sparse: ptr=3, only requester 2 valid, then only requester 1
    req_valid = 4'b0100; #1;
    chk("sparse_grant2", 32'(grant), 32'b0100);
    nxt();
    chk("sparse_data2", 32'(out_data), 32'hA2);
    req_valid = 4'b0010; #1;
    chk("sparse_grant1", 32'(grant), 32'b0010);
    nxt();
    chk("sparse_data1", 32'(out_data), 32'hA1);

    // simultaneous drain and accept from requester 0 (ptr=2 wraps to 0)
    req_valid = 4'b0001; set_data(8'h11, 8'hA1, 8'hA2, 8'hA3); #1;
    chk("da_grant", 32'(grant), 32'b0001);
    nxt();
    chk("da_valid", 32'(out_valid), 1);
    chk("da_data",  32'(out_data),  32'h11);
    req_valid = 4'b0000;
    nxt();
    chk("drain_empty", 32'(out_valid), 0);
    chk("empty_hold",  32'(out_data),  32'h11);
    out_ready = 1'b0;
    nxt();
    chk("empty_stay", 32'(out_valid), 0);

    // reset mid-stream while holding 77 (ptr=1, search reaches requester 0)
    req_valid = 4'b0001; set_data(8'h77, 8'hA1, 8'hA2, 8'hA3); #1;
    chk("m_grant", 32'(grant), 32'b0001);
    nxt();
    chk("m_full", 32'(out_data), 32'h77);
    req_valid = 4'b0000; rst = 1'b1; out_ready = 1'b1; #1;
    chk("m_rst_grant", 32'(grant), 0);
    chk("m_rst_ready", 32'(req_ready), 0);
    nxt();
    chk("m_rst_valid", 32'(out_valid), 0);
    chk("m_rst_data",  32'(out_data),  0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      nxt();
      chk("m_post_valid", 32'(out_valid), 0);
    end
    req_valid = 4'hF; set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3); #1;
    chk("m_post_grant", 32'(grant), 32'b0001);
    nxt();
    chk("m_post_data", 32'(out_data), 32'hA0);
    chk("no_77_drain", 32'(saw77), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mux_round_robin_arbiter.md
MUX_ROUND_ROBIN_ARBITER -- requirements
Module: mux_round_robin_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the output mux (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, data word width per requester.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester word-available flag.
REQ-006 SHALL have port req_data  input  N_REQ*WIDTH  packed requester words; requester i at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port req_ready  output  N_REQ  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 SHALL have port out_valid  output  1  output register holds a word.
REQ-009 SHALL have port out_data  output  WIDTH  held word.
REQ-010 SHALL have port out_ready  input  1  downstream accept; drain when out_valid and out_ready are both high.
REQ-011 SHALL have port grant  output  N_REQ  one-hot mux select of the current-cycle winner; all zero when no winner.

Function
REQ-012 SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 SHALL define "space" as state EMPTY, or state FULL with out_ready=1 in the same cycle.
REQ-014 SHALL choose the winner combinationally only when space is present: the first requester with req_valid=1, searching ptr, ptr+1, ... mod N_REQ.
REQ-015 SHALL drive req_ready = grant; at most one req_ready bit is high; all bits are low when no space is present or no requester is valid.
REQ-016 SHALL, on a transfer, load the winner's req_data into out_data and set out_valid=1 at the next edge, giving 1-cycle latency.
REQ-017 SHALL, on a transfer from requester w, set ptr to w+1, wrapping from N_REQ-1 to 0; ptr is unchanged when no transfer occurs.
REQ-018 SHALL go FULL->EMPTY on a drain with no transfer in the same cycle.
REQ-019 SHALL stay FULL and load the new word on a simultaneous drain and transfer, sustaining 1 word/cycle.
REQ-020 SHALL keep out_data and out_valid stable while FULL and out_ready=0.
REQ-021 SHALL select data via the grant-driven mux only; it SHALL NOT duplicate, reorder or drop accepted words.
REQ-022 SHALL allow a requester to deassert req_valid before being granted, with no side effect.
REQ-023 SHALL leave out_data unchanged while EMPTY.

Reset
REQ-024 SHALL, with rst high at an edge, set state EMPTY, out_valid=0, out_data=0 and ptr=0.
REQ-025 SHALL hold req_ready=0 and grant=0 while rst is high.
REQ-026 SHALL discard a held word when reset is asserted mid-operation; the word is not delivered afterwards.

Structure
REQ-027 SHALL place state_t {ST_EMPTY, ST_FULL} and the default N_REQ/WIDTH constants in shared package mux_arb_pkg.
REQ-028 SHALL contain one combinational sub-module, round_robin_select (inputs: valid vector, ptr, space enable; output: one-hot grant).
REQ-029 SHALL keep ptr width $clog2(N_REQ) and wrap explicitly so that non-power-of-two N_REQ is correct.

Verification
REQ-030 SHALL cover reset: drive rst for 2 cycles with all req_valid=1 -> out_valid=0, out_data=0, req_ready=0 during reset; first grant after reset = requester 0.
REQ-031 SHALL cover saturation: all 4 requesters valid with data 8'hA0..8'hA3, out_ready=1 -> out_data sequence A0,A1,A2,A3,A0 on consecutive cycles, one-hot grant rotating, ptr wrapping 3->0.
REQ-032 SHALL cover backpressure: FULL with 8'h55, out_ready=0 for 5 cycles while requesters are valid -> out_data stays 55, req_ready=0 throughout, then resumes in round-robin order.
REQ-033 SHALL cover sparse requests: only requester 2 valid with ptr=3 -> grant=4'b0100, ptr becomes 3; then only requester 1 valid -> grant=4'b0010.
REQ-034 SHALL cover simultaneous drain and accept: FULL, out_ready=1, requester 0 valid with 8'h11 -> state stays FULL, out_data=11 next cycle, no bubble.
REQ-035 SHALL cover reset mid-stream: assert rst while FULL with 8'h77 -> out_valid=0 next cycle, 77 never observed on a drain.
